sar_ctrl: RTL
=============

SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8: conversion resolution in bits, legal range 2..16.
REQ-002 The block SHALL have parameter TRST, default 1: number of cycles snh_rst is held high, legal range 1..15.
REQ-003 The block SHALL have parameter TSAMPLE, default 2: number of cycles sample is held high, legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: conversion request, level-sampled.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels an in-flight conversion.
REQ-008 The block SHALL have port comp, input, 1 bit: comparator decision, 1 when the sampled input is above the DAC output.
REQ-009 The block SHALL have port snh_rst, output, 1 bit: S/H reset-mode control, drives the S/H rst pin.
REQ-010 The block SHALL have port sample, output, 1 bit: S/H track-mode control.
REQ-011 The block SHALL have port cs_trigger, output, 1 bit: charge-sharing trigger to the S/H.
REQ-012 The block SHALL have port dac_code, output, N bits: current trial code to the capacitive DAC.
REQ-013 The block SHALL have port dout, output, N bits: last completed conversion result.
REQ-014 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking dout as updated.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 All outputs SHALL be registered (Moore), with no combinational path from any input to any output.
REQ-017 The FSM SHALL have the states IDLE, RESET, SAMPLE, SHARE, CONV and DONE.
REQ-018 IDLE: start=1 at an edge SHALL cause a move to RESET and load a cycle counter with TRST-1; start=0 SHALL keep the FSM in IDLE.
REQ-019 RESET: snh_rst SHALL be 1; when the counter reaches 0 the FSM SHALL move to SAMPLE and load the counter with TSAMPLE-1.
REQ-020 SAMPLE: sample SHALL be 1; when the counter reaches 0 the FSM SHALL move to SHARE.
REQ-021 snh_rst and sample SHALL never be 1 in the same cycle.
REQ-022 SHARE: cs_trigger SHALL be 1 for exactly one cycle, after which the FSM SHALL move to CONV.
REQ-023 On entry to CONV, dac_code SHALL be set to 1<<(N-1) and the bit index k SHALL be set to N-1.
REQ-024 Each CONV edge SHALL resolve bit k: keep dac_code[k] if comp=1, clear it if comp=0, and if k>0 set dac_code[k-1] and decrement k.
REQ-025 When the edge resolves k=0, the FSM SHALL move to DONE, set dout to the resolved code and assert valid.
REQ-026 CONV SHALL last exactly N cycles.
REQ-027 comp SHALL be ignored in every state except CONV.
REQ-028 DONE: valid SHALL be 1 for exactly one cycle and the FSM SHALL move unconditionally to IDLE; start seen during DONE SHALL be ignored.
REQ-029 Latency: if start is sampled at edge E0, valid SHALL be high in the cycle after edge E0+TRST+TSAMPLE+1+N.
REQ-030 start while busy=1 SHALL be ignored; it SHALL NOT be queued.
REQ-031 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, clear dac_code, drive snh_rst, sample and cs_trigger to 0, keep dout unchanged and not assert valid.
REQ-032 abort in IDLE SHALL have no effect.
REQ-033 If start and abort are both 1 in IDLE, the FSM SHALL stay in IDLE (abort wins).
REQ-034 dac_code SHALL be 0 in every state except CONV, and SHALL hold its final resolved value during the DONE cycle.

Reset
REQ-035 rst=1 at an edge SHALL force IDLE, with snh_rst=0, sample=0, cs_trigger=0, dac_code=0, dout=0, valid=0 and busy=0.
REQ-036 rst SHALL take priority over abort and start.
REQ-037 rst asserted mid-conversion SHALL discard the partial result and SHALL NOT produce a valid pulse.
REQ-038 After rst deasserts, the first start SHALL be accepted at the first edge where rst=0.

Verification
REQ-039 N=4, TRST=1, TSAMPLE=2: start for 1 cycle, comp sequence 1,0,1,1 -> dac_code steps 1000, 1100, 1010, 1011; dout=4'hB; valid high exactly 8 edges after the start edge.
REQ-040 N=4: comp held at 0 -> dout=0; comp held at 1 -> dout=4'hF; each conversion produces exactly one valid pulse.
REQ-041 start held high continuously -> back-to-back conversions separated by exactly one IDLE cycle, with busy low only in that cycle.
REQ-042 abort during the second CONV cycle -> IDLE at the next edge, no valid pulse, dout retains its prior value, dac_code=0.
REQ-043 rst during SAMPLE -> all outputs at reset values at the next edge; start on the following edge restarts the conversion from RESET.
REQ-044 Checker: snh_rst and sample are never high together; cs_trigger pulses exactly once per completed conversion, exactly one cycle before dac_code becomes 1<<(N-1).

Source files
------------

// File: rtl/sar_ctrl_if.sv
// Bundle of SAR controller control/data signals between the requester,
// the S/H + DAC + comparator analog front end, and the controller.
interface sar_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic         abort;
  logic         comp;
  logic         snh_rst;
  logic         sample;
  logic         cs_trigger;
  logic [N-1:0] dac_code;
  logic [N-1:0] dout;
  logic         valid;
  logic         busy;

  modport slave (
    input  start, abort, comp,
    output snh_rst, sample, cs_trigger, dac_code, dout, valid, busy
  );

  modport master (
    output start, abort, comp,
    input  snh_rst, sample, cs_trigger, dac_code, dout, valid, busy
  );
endinterface

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC sequencer: S/H reset, track, charge-share,
// then an N-cycle binary search on the DAC code. All outputs are flops.
module sar_ctrl #(
  parameter int N       = 8,
  parameter int TRST    = 1,
  parameter int TSAMPLE = 2
) (
  input  logic      clk,
  input  logic      rst,
  sar_ctrl_if.slave bus
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_SAMPLE, S_SHARE, S_CONV, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [N-1:0]  dac_q, dac_d, dout_q, dout_d, trial;
  logic          snh_rst_q, snh_rst_d, sample_q, sample_d, cs_q, cs_d;
  logic          valid_q, valid_d, busy_q, busy_d;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      dac_q     <= '0;
      dout_q    <= '0;
      snh_rst_q <= 1'b0;
      sample_q  <= 1'b0;
      cs_q      <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      dac_q     <= dac_d;
      dout_q    <= dout_d;
      snh_rst_q <= snh_rst_d;
      sample_q  <= sample_d;
      cs_q      <= cs_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: every combinational output is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d = S_RESET;
            cnt_d   = 4'(TRST - 1);
          end
        end
        S_RESET: begin
          if (cnt_q == '0) begin
            state_d = S_SAMPLE;
            cnt_d   = 4'(TSAMPLE - 1);
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (cnt_q == '0) state_d = S_SHARE;
          else             cnt_d   = cnt_q - 4'd1;
        end
        S_SHARE: state_d = S_CONV;
        S_CONV:  if (k_q == '0) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    trial = dac_q;
    trial[k_q] = bus.comp;
    if (k_q != '0) trial[k_q - KW'(1)] = 1'b1;

    dac_d  = '0;
    k_d    = k_q;
    dout_d = dout_q;
    if ((state_q == S_SHARE) && (state_d == S_CONV)) begin
      dac_d = {1'b1, {(N-1){1'b0}}};
      k_d   = KW'(N - 1);
    end else if ((state_q == S_CONV) && (state_d != S_IDLE)) begin
      dac_d = trial;
      k_d   = k_q - KW'(1);
      if (state_d == S_DONE) dout_d = trial;
    end

    snh_rst_d = (state_d == S_RESET);
    sample_d  = (state_d == S_SAMPLE);
    cs_d      = (state_d == S_SHARE);
    valid_d   = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  assign bus.snh_rst    = snh_rst_q;
  assign bus.sample     = sample_q;
  assign bus.cs_trigger = cs_q;
  assign bus.dac_code   = dac_q;
  assign bus.dout       = dout_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;

endmodule
